// File: rtl/ps2_action_queue.sv
// Debounces six PS/2 action levels, turns presses and direction auto-repeats into events,
// and queues them in a 4-entry first-word-fall-through FIFO; pending flags hold events while the FIFO is full.
module ps2_action_queue #(
  parameter int STABLE_CYCLES = 16,
  parameter int REPEAT_DELAY  = 12_500_000,
  parameter int REPEAT_PERIOD = 2_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] acoes_in,
  input  logic       rd_en,
  output logic [5:0] held,
  output logic       ev_valid,
  output logic [2:0] ev_code,
  output logic       ev_repeat,
  output logic [2:0] ev_count,
  output logic       overflow
);

  localparam int CW   = $clog2(STABLE_CYCLES) + 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(RMAX) + 1;

  logic [5:0]    sync1, sync2;
  logic [CW-1:0] cnt [6];
  logic [5:0]    flip;
  logic [5:0]    press;

  always_comb begin
    flip = '0;
    for (int i = 0; i < 6; i++)
      flip[i] = (sync2[i] != held[i]) && (cnt[i] == CW'(STABLE_CYCLES - 1));
    press = flip & ~held;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      held  <= '0;
      for (int i = 0; i < 6; i++) cnt[i] <= '0;
    end else begin
      sync1 <= acoes_in;
      sync2 <= sync1;
      held  <= held ^ flip;
      for (int i = 0; i < 6; i++) begin
        if (sync2[i] == held[i] || flip[i]) cnt[i] <= '0;
        else                                cnt[i] <= cnt[i] + CW'(1);
      end
    end
  end

  // One repeat timer shared by all directions; any direction change restarts the delay.
  logic [TW-1:0] timer;
  logic          first_done;
  logic          dir_on, dir_chg, fire;
  logic [5:0]    rep_set;

  always_comb begin
    dir_on  = |held[3:0];
    dir_chg = |flip[3:0];
    fire    = 1'b0;
    if (dir_on && !dir_chg)
      fire = first_done ? (timer == TW'(REPEAT_PERIOD - 1)) : (timer == TW'(REPEAT_DELAY - 1));
    rep_set = fire ? {2'b00, held[3:0]} : 6'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer      <= '0;
      first_done <= 1'b0;
    end else if (!dir_on || dir_chg) begin
      timer      <= '0;
      first_done <= 1'b0;
    end else if (fire) begin
      timer      <= '0;
      first_done <= 1'b1;
    end else begin
      timer      <= timer + TW'(1);
    end
  end

  logic [5:0] pending, rep_flag;
  logic [5:0] grant_mask, pend_left, set_bits;
  logic [2:0] gidx;
  logic       pop, push;
  logic [3:0] mem [4];
  logic [1:0] wptr, rptr;

  always_comb begin
    gidx = 3'd0;
    for (int i = 5; i >= 0; i--)
      if (pending[i]) gidx = 3'(i);
    pop        = rd_en && ev_valid;
    push       = (|pending) && ((ev_count != 3'd4) || pop);
    grant_mask = push ? (6'b000001 << gidx) : 6'b0;
    pend_left  = pending & ~grant_mask;
    set_bits   = press | rep_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      rep_flag <= '0;
      overflow <= 1'b0;
    end else begin
      pending  <= pend_left | set_bits;
      overflow <= overflow | (|(set_bits & pend_left));
      for (int i = 0; i < 6; i++) begin
        if (press[i])                     rep_flag[i] <= 1'b0;
        else if (rep_set[i] && !pend_left[i]) rep_flag[i] <= 1'b1;
      end
    end
  end

  // When full with a simultaneous pop, wptr==rptr: the head leaves as the new entry lands in its slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      ev_count <= '0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= {rep_flag[gidx], gidx};
        wptr      <= wptr + 2'd1;
      end
      if (pop) rptr <= rptr + 2'd1;
      ev_count <= ev_count + {2'b00, push} - {2'b00, pop};
    end
  end

  always_comb begin
    ev_valid  = (ev_count != 3'd0);
    ev_code   = ev_valid ? mem[rptr][2:0] : 3'd0;
    ev_repeat = ev_valid ? mem[rptr][3]   : 1'b0;
  end

endmodule

// File: tb/tb_ps2_action_queue.sv
// Bench for ps2_action_queue: directed scenarios plus random key activity, checked every cycle against an event-level model.
module tb_ps2_action_queue;

  localparam int S  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] acoes_in = '0;
  logic       rd_en = 1'b0;
  logic [5:0] held;
  logic       ev_valid;
  logic [2:0] ev_code;
  logic       ev_repeat;
  logic [2:0] ev_count;
  logic       overflow;

  ps2_action_queue #(.STABLE_CYCLES(S), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .rst_n(rst_n), .acoes_in(acoes_in), .rd_en(rd_en),
    .held(held), .ev_valid(ev_valid), .ev_code(ev_code), .ev_repeat(ev_repeat),
    .ev_count(ev_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model: input delay line, per-key mismatch run length, hold age of the direction set,
  // pending events per key and the FIFO as a queue of {repeat, code}.
  bit [5:0] m_s1, m_s2, m_held, m_pend, m_rflag;
  int       m_run [6];
  int       m_age;
  bit [3:0] m_q [$];
  bit       m_ovf;

  task automatic m_reset();
    m_s1 = '0; m_s2 = '0; m_held = '0; m_pend = '0; m_rflag = '0;
    for (int i = 0; i < 6; i++) m_run[i] = 0;
    m_age = 0; m_q.delete(); m_ovf = 0;
  endtask

  task automatic model_step(input bit [5:0] a, input bit r);
    bit [5:0] nh, press, rep;
    bit pop, can, fire;
    nh = m_held;
    for (int i = 0; i < 6; i++) begin
      if (m_s2[i] == m_held[i]) m_run[i] = 0;
      else if (m_run[i] == S - 1) begin nh[i] = m_s2[i]; m_run[i] = 0; end
      else m_run[i]++;
    end
    fire = 0;
    if (nh[3:0] != m_held[3:0] || nh[3:0] == 0) m_age = 0;
    else begin
      m_age++;
      if (m_age == RD || (m_age > RD && (m_age - RD) % RP == 0)) fire = 1;
    end
    press = nh & ~m_held;
    rep = fire ? {2'b00, m_held[3:0]} : 6'b0;
    pop = r && (m_q.size() > 0);
    can = (m_q.size() < 4) || pop;
    if (pop) void'(m_q.pop_front());
    if (can && m_pend != 0) begin
      for (int i = 0; i < 6; i++) begin
        if (m_pend[i]) begin
          m_q.push_back({m_rflag[i], 3'(i)});
          m_pend[i] = 0;
          break;
        end
      end
    end
    for (int i = 0; i < 6; i++) begin
      if (press[i] || rep[i]) begin
        if (m_pend[i]) m_ovf = 1;
        if (press[i]) m_rflag[i] = 0;
        else if (!m_pend[i]) m_rflag[i] = 1;
        m_pend[i] = 1;
      end
    end
    m_s2 = m_s1; m_s1 = a; m_held = nh;
  endtask

  task automatic compare_all();
    bit [3:0] head;
    head = (m_q.size() > 0) ? m_q[0] : 4'd0;
    check("held", held, m_held);
    check("ev_valid", ev_valid, m_q.size() > 0);
    check("ev_code", ev_code, head[2:0]);
    check("ev_repeat", ev_repeat, head[3]);
    check("ev_count", ev_count, m_q.size());
    check("overflow", overflow, m_ovf);
  endtask

  task automatic tick(input logic [5:0] a, input logic r);
    acoes_in = a;
    rd_en = r;
    @(posedge clk);
    model_step(a, r);
    #1;
    compare_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int rep_cnt, press_cnt;
  logic [2:0] exp_codes [3];
  logic [5:0] cur;

  initial begin
    m_reset();
    #3;
    compare_all();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) tick(6'h00, 1'b0);

    // Single press of key 4: held after 2+S edges, event one edge later.
    repeat (5) tick(6'h10, 1'b0);
    check("press_lat_before", held[4], 0);
    tick(6'h10, 1'b0);
    check("press_lat_held", held[4], 1);
    tick(6'h10, 1'b0);
    check("press_code", ev_code, 4);
    check("press_count", ev_count, 1);
    tick(6'h10, 1'b1);
    check("pop_count", ev_count, 0);
    repeat (8) tick(6'h00, 1'b0);

    // Glitch shorter than S cycles.
    repeat (3) tick(6'h04, 1'b0);
    repeat (10) tick(6'h00, 1'b0);
    check("glitch_held", held, 0);
    check("glitch_valid", ev_valid, 0);

    // Three keys rise together: lowest index first.
    exp_codes[0] = 3'd0; exp_codes[1] = 3'd1; exp_codes[2] = 3'd5;
    repeat (10) tick(6'h23, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("multi_code", ev_code, exp_codes[k]);
      check("multi_rep", ev_repeat, 0);
      tick(6'h23, 1'b1);
    end
    repeat (10) tick(6'h00, 1'b0);

    // Hold "right": one press then repeats at +20, +28, ... until the release is filtered.
    rep_cnt = 0; press_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      if (ev_valid) begin
        if (ev_repeat) rep_cnt++;
        else press_cnt++;
      end
      tick((k < 70) ? 6'h08 : 6'h00, ev_valid);
    end
    check("repeat_events", rep_cnt, 7);
    check("repeat_press", press_cnt, 1);

    // Fill the FIFO without reads, then coalesce a re-press of the pending key.
    repeat (12) tick(6'h37, 1'b0);
    check("full_count", ev_count, 4);
    repeat (6) tick(6'h17, 1'b0);
    repeat (6) tick(6'h37, 1'b0);
    check("coalesce_ovf", overflow, 1);
    check("full_head", ev_code, 0);
    tick(6'h37, 1'b1);
    check("full_pop_count", ev_count, 4);
    for (int k = 0; k < 40; k++) tick(6'h00, (m_q.size() > 0) ? 1'b1 : 1'b0);

    // Randomized key activity and reads, including reads when empty.
    cur = '0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 9) == 0) cur = cur ^ 6'($urandom_range(1, 63));
      tick(cur, ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
    end
    for (int k = 0; k < 60; k++) tick(6'h00, 1'b1);

    // Asynchronous reset with three events queued, keys still held across release.
    repeat (10) tick(6'h31, 1'b0);
    check("pre_reset_count", ev_count, 3);
    rst_n = 1'b0;
    #2;
    m_reset();
    check("rst_held", held, 0);
    check("rst_valid", ev_valid, 0);
    check("rst_code", ev_code, 0);
    check("rst_repeat", ev_repeat, 0);
    check("rst_count", ev_count, 0);
    check("rst_ovf", overflow, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) tick(6'h31, 1'b0);
    check("post_reset_held", held, 6'h31);
    repeat (3) tick(6'h31, 1'b0);
    check("post_reset_count", ev_count, 3);
    for (int k = 0; k < 20; k++) tick(6'h00, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ps2_action_queue.md
PS2_ACTION_QUEUE -- requirements
Module: ps2_action_queue

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 16: cycles a synchronized action bit must hold a new value before the filtered level changes.
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 12_500_000: cycles a direction is held before its first auto-repeat.
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 2_500_000: cycles between later auto-repeats.
REQ-004 The block SHALL have these ports:
  clk  input  1  system clock
  rst_n  input  1  asynchronous active-low reset
  acoes_in  input  6  action levels from the PS/2 receiver (ps2_clk domain, asynchronous to clk): 0=up, 1=left, 2=down, 3=right, 4=space, 5=enter
  rd_en  input  1  consumer pop strobe, one pulse per event
  held  output  6  filtered action levels
  ev_valid  output  1  FIFO non-empty
  ev_code  output  3  action index of head event
  ev_repeat  output  1  head event is an auto-repeat
  ev_count  output  3  FIFO occupancy, 0..4
  overflow  output  1  sticky: an event coalesced while its pending flag was already set

Function
REQ-005 Each acoes_in bit SHALL pass a 2-flop synchronizer; the synchronized value is the only use of acoes_in.
REQ-006 Per bit, a stability counter SHALL reset whenever the synchronized value equals held; otherwise it increments, and held updates on the cycle the counter reaches STABLE_CYCLES-1.
REQ-007 Latency from an acoes_in change to held SHALL be 2+STABLE_CYCLES cycles; a glitch shorter than STABLE_CYCLES cycles SHALL not change held.
REQ-008 A 0->1 transition of held[i] SHALL set pending[i] with repeat flag 0; 1->0 transitions generate no event.
REQ-009 Auto-repeat applies to indices 0-3 only; one shared timer SHALL restart from 0 whenever held[3:0] changes or is all zero.
REQ-010 While held[3:0] is non-zero, timer reaching REPEAT_DELAY-1 (first) and then every REPEAT_PERIOD cycles SHALL set pending with repeat flag 1 for every set held[3:0] bit.
REQ-011 Setting an already-set pending bit SHALL coalesce to one event and set overflow; a press event overrides a pending repeat flag to 0.
REQ-012 Arbiter: each cycle, if FIFO not full (or a pop occurs that cycle), the lowest-index set pending bit SHALL be pushed as {repeat,index} and cleared the same cycle.
REQ-013 FIFO SHALL be 4 entries, first-word-fall-through; ev_code/ev_repeat show the head whenever ev_valid=1, and are 0 when empty.
REQ-014 rd_en with ev_valid=1 SHALL pop on that edge; rd_en when empty SHALL be ignored.
REQ-015 Simultaneous push and pop when full SHALL leave ev_count at 4; simultaneous push and pop when empty is not a bypass (push lands, count becomes 1).
REQ-016 When FIFO is full with no pop, pending bits SHALL persist; no event is lost except by coalescing.
REQ-017 Pointers SHALL wrap modulo 4; ev_count SHALL equal pushes minus pops.

Reset
REQ-018 rst_n=0 SHALL asynchronously clear synchronizers, stability counters, held, pending, repeat flags, timer, FIFO pointers and contents, overflow; outputs all 0.
REQ-019 Reset asserted mid-operation SHALL discard queued and pending events; after release, keys still pressed SHALL produce new press events after 2+STABLE_CYCLES cycles.
REQ-020 overflow SHALL clear only on reset.

Verification
REQ-021 STABLE_CYCLES=4: acoes_in[4] 0->1 held -> held[4]=1 after 6 cycles, ev_valid=1, ev_code=4, ev_repeat=0, ev_count=1; rd_en pulse -> ev_count=0.
REQ-022 acoes_in[2] high 3 cycles then low -> held stays 0, no event.
REQ-023 acoes_in=6'b100011 rising same cycle -> events popped in order code 0, 1, 5, all ev_repeat=0.
REQ-024 REPEAT_DELAY=20, REPEAT_PERIOD=8, hold acoes_in[3] -> press event, repeat at +20 cycles after held rise, then every 8 cycles, ev_repeat=1; release stops repeats.
REQ-025 No reads, 5 distinct presses -> ev_count=4, 5th remains pending; one pop -> 5th enters, count stays 4; re-press same key while pending -> overflow=1.
REQ-026 Assert rst_n=0 with ev_count=3 -> all outputs 0 immediately without clock edge.
